// File: rtl/reset_sequencer_if.sv
// Bundles the lock/request inputs and the reset/diagnostic outputs of the
// reset sequencer so the sequencer and its neighbours share one connection.
interface reset_sequencer_if #(
   parameter int NUM_STAGES = 3
);
   logic                  clk_locked;
   logic                  sw_reset_req;
   logic [NUM_STAGES-1:0] rst_stage_out;
   logic                  sys_ready;
   logic                  lock_lost_sticky;
   logic [7:0]            lock_loss_count;
   logic [2:0]            seq_state;

   modport master (
      input  clk_locked,
      input  sw_reset_req,
      output rst_stage_out,
      output sys_ready,
      output lock_lost_sticky,
      output lock_loss_count,
      output seq_state
   );

   modport slave (
      output clk_locked,
      output sw_reset_req,
      input  rst_stage_out,
      input  sys_ready,
      input  lock_lost_sticky,
      input  lock_loss_count,
      input  seq_state
   );
endinterface

// File: rtl/reset_sequencer.sv
// Holds the datapath in reset until the system clock has been locked for a
// stable window, then releases per-subsystem resets one stage at a time.
// Lock loss or a host software reset puts every stage back into reset.
module reset_sequencer #(
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int STAGE_GAP_CYCLES   = 16,
   parameter int NUM_STAGES         = 3
) (
   input  logic              clk,
   input  logic              rst,
   reset_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      HOLD    = 3'd0,
      STABLE  = 3'd1,
      RELEASE = 3'd2,
      RUN     = 3'd3,
      SWRST   = 3'd4
   } state_t;

   // Counters compare against the last value before the event fires, so a
   // window of N edges ends when the counter already holds N-1.
   localparam logic [15:0] LOCK_LAST = 16'(LOCK_STABLE_CYCLES - 1);
   localparam logic [15:0] GAP_LAST  = 16'(STAGE_GAP_CYCLES - 1);
   localparam logic [3:0]  STAGES    = 4'(NUM_STAGES);

   state_t                state, state_next;
   logic [15:0]           stab_cnt, stab_cnt_next;
   logic [15:0]           gap_cnt, gap_cnt_next;
   logic [3:0]            rel_cnt, rel_cnt_next;
   logic [NUM_STAGES-1:0] stage_q, stage_next;
   logic                  ready_q, ready_next;
   logic                  sticky_q, sticky_next;
   logic [7:0]            loss_q, loss_next;
   logic                  abort_loss;

   // Next-state logic: walks HOLD -> STABLE -> RELEASE -> RUN and handles the
   // two abort paths, with lock loss taking precedence over a software reset.
   always_comb begin
      state_next    = state;
      stab_cnt_next = stab_cnt;
      gap_cnt_next  = gap_cnt;
      rel_cnt_next  = rel_cnt;
      ready_next    = ready_q;
      sticky_next   = sticky_q;
      loss_next     = loss_q;
      abort_loss    = 1'b0;

      case (state)
         HOLD: begin
            stab_cnt_next = '0;
            gap_cnt_next  = '0;
            rel_cnt_next  = '0;
            ready_next    = 1'b0;
            if (bus.clk_locked) begin
               state_next = STABLE;
            end
         end
         STABLE: begin
            rel_cnt_next = '0;
            ready_next   = 1'b0;
            if (!bus.clk_locked) begin
               state_next    = HOLD;
               stab_cnt_next = '0;
            end else if (stab_cnt == LOCK_LAST) begin
               state_next    = RELEASE;
               stab_cnt_next = '0;
               gap_cnt_next  = '0;
               rel_cnt_next  = 4'd1;
            end else begin
               stab_cnt_next = stab_cnt + 16'd1;
            end
         end
         RELEASE: begin
            if (!bus.clk_locked) begin
               abort_loss = 1'b1;
            end else if (bus.sw_reset_req) begin
               state_next   = SWRST;
               gap_cnt_next = '0;
               rel_cnt_next = '0;
               ready_next   = 1'b0;
            end else if (gap_cnt == GAP_LAST) begin
               gap_cnt_next = '0;
               if (rel_cnt == STAGES) begin
                  state_next = RUN;
                  ready_next = 1'b1;
               end else begin
                  rel_cnt_next = rel_cnt + 4'd1;
               end
            end else begin
               gap_cnt_next = gap_cnt + 16'd1;
            end
         end
         RUN: begin
            if (!bus.clk_locked) begin
               abort_loss = 1'b1;
            end else if (bus.sw_reset_req) begin
               state_next   = SWRST;
               gap_cnt_next = '0;
               rel_cnt_next = '0;
               ready_next   = 1'b0;
            end
         end
         SWRST: begin
            rel_cnt_next = '0;
            ready_next   = 1'b0;
            if (!bus.clk_locked) begin
               abort_loss = 1'b1;
            end else if (gap_cnt == GAP_LAST) begin
               state_next   = HOLD;
               gap_cnt_next = '0;
            end else begin
               gap_cnt_next = gap_cnt + 16'd1;
            end
         end
         default: begin
            state_next    = HOLD;
            stab_cnt_next = '0;
            gap_cnt_next  = '0;
            rel_cnt_next  = '0;
            ready_next    = 1'b0;
         end
      endcase

      if (abort_loss) begin
         state_next    = HOLD;
         stab_cnt_next = '0;
         gap_cnt_next  = '0;
         rel_cnt_next  = '0;
         ready_next    = 1'b0;
         sticky_next   = 1'b1;
         loss_next     = (loss_q == 8'hFF) ? 8'hFF : loss_q + 8'd1;
      end
   end

   // Stage k is held in reset while fewer than k+1 stages have been released;
   // deriving the outputs from a monotonic count keeps them glitch-free.
   always_comb begin
      stage_next = '1;
      for (int i = 0; i < NUM_STAGES; i++) begin
         stage_next[i] = (4'(i) >= rel_cnt_next);
      end
   end

   // State, counter and output registers; rst wins over everything else.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= HOLD;
         stab_cnt <= '0;
         gap_cnt  <= '0;
         rel_cnt  <= '0;
         stage_q  <= '1;
         ready_q  <= 1'b0;
         sticky_q <= 1'b0;
         loss_q   <= '0;
      end else begin
         state    <= state_next;
         stab_cnt <= stab_cnt_next;
         gap_cnt  <= gap_cnt_next;
         rel_cnt  <= rel_cnt_next;
         stage_q  <= stage_next;
         ready_q  <= ready_next;
         sticky_q <= sticky_next;
         loss_q   <= loss_next;
      end
   end

   assign bus.rst_stage_out    = stage_q;
   assign bus.sys_ready        = ready_q;
   assign bus.lock_lost_sticky = sticky_q;
   assign bus.lock_loss_count  = loss_q;
   assign bus.seq_state        = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with LOCK_STABLE_CYCLES=8,
// STAGE_GAP_CYCLES=4, NUM_STAGES=3. Expected values are hand-derived edge
// counts relative to the first locked edge E0.
module tb_reset_sequencer;

   logic clk;
   logic rst;
   int   checks;
   int   passes;

   reset_sequencer_if #(.NUM_STAGES(3)) bus ();

   reset_sequencer #(
      .LOCK_STABLE_CYCLES(8),
      .STAGE_GAP_CYCLES  (4),
      .NUM_STAGES        (3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Free-running 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advances n active edges and settles 1 unit past the last one, so both
   // sampling and input changes happen away from the edge.
   task automatic stepCycles(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic applyStimulus(input logic locked, input logic sw);
      bus.clk_locked   = locked;
      bus.sw_reset_req = sw;
   endtask

   // From HOLD: lock, first edge is E0, then 20 more edges reach RUN.
   task automatic runUp(input string tag);
      applyStimulus(1'b1, 1'b0);
      stepCycles(1);
      checkOutput({tag, "_stable"}, 16'(bus.seq_state), 16'd1);
      stepCycles(20);
      checkOutput({tag, "_run_state"}, 16'(bus.seq_state), 16'd3);
      checkOutput({tag, "_run_ready"}, 16'(bus.sys_ready), 16'd1);
      checkOutput({tag, "_run_stages"}, 16'(bus.rst_stage_out), 16'b000);
   endtask

   task automatic doReset();
      rst = 1'b1;
      stepCycles(2);
      rst = 1'b0;
   endtask

   initial begin
      checks = 0;
      passes = 0;
      rst    = 1'b1;
      applyStimulus(1'b0, 1'b0);

      // Reset then steady lock
      stepCycles(3);
      checkOutput("rst_stages", 16'(bus.rst_stage_out), 16'b111);
      checkOutput("rst_ready", 16'(bus.sys_ready), 16'd0);
      checkOutput("rst_sticky", 16'(bus.lock_lost_sticky), 16'd0);
      checkOutput("rst_count", 16'(bus.lock_loss_count), 16'd0);
      checkOutput("rst_state", 16'(bus.seq_state), 16'd0);
      rst = 1'b0;
      stepCycles(1);
      checkOutput("hold_unlocked", 16'(bus.seq_state), 16'd0);
      applyStimulus(1'b1, 1'b0);
      stepCycles(1);
      checkOutput("e0_state", 16'(bus.seq_state), 16'd1);
      stepCycles(7);
      checkOutput("e7_stages", 16'(bus.rst_stage_out), 16'b111);
      checkOutput("e7_state", 16'(bus.seq_state), 16'd1);
      stepCycles(1);
      checkOutput("e8_stages", 16'(bus.rst_stage_out), 16'b110);
      checkOutput("e8_state", 16'(bus.seq_state), 16'd2);
      stepCycles(3);
      checkOutput("e11_stages", 16'(bus.rst_stage_out), 16'b110);
      stepCycles(1);
      checkOutput("e12_stages", 16'(bus.rst_stage_out), 16'b100);
      stepCycles(4);
      checkOutput("e16_stages", 16'(bus.rst_stage_out), 16'b000);
      checkOutput("e16_state", 16'(bus.seq_state), 16'd2);
      stepCycles(3);
      checkOutput("e19_ready", 16'(bus.sys_ready), 16'd0);
      stepCycles(1);
      checkOutput("e20_ready", 16'(bus.sys_ready), 16'd1);
      checkOutput("e20_state", 16'(bus.seq_state), 16'd3);

      // Lock bounce during STABLE
      doReset();
      applyStimulus(1'b1, 1'b0);
      stepCycles(5);
      applyStimulus(1'b0, 1'b0);
      stepCycles(1);
      checkOutput("bounce_hold", 16'(bus.seq_state), 16'd0);
      applyStimulus(1'b1, 1'b0);
      stepCycles(1);
      checkOutput("bounce_e1_state", 16'(bus.seq_state), 16'd1);
      stepCycles(7);
      checkOutput("bounce_e1p7_stages", 16'(bus.rst_stage_out), 16'b111);
      stepCycles(1);
      checkOutput("bounce_e1p8_stages", 16'(bus.rst_stage_out), 16'b110);
      checkOutput("bounce_sticky", 16'(bus.lock_lost_sticky), 16'd0);
      checkOutput("bounce_count", 16'(bus.lock_loss_count), 16'd0);
      stepCycles(12);
      checkOutput("bounce_ready", 16'(bus.sys_ready), 16'd1);

      // Lock loss in RUN, then full re-sequence
      applyStimulus(1'b0, 1'b0);
      stepCycles(1);
      checkOutput("runloss_stages", 16'(bus.rst_stage_out), 16'b111);
      checkOutput("runloss_ready", 16'(bus.sys_ready), 16'd0);
      checkOutput("runloss_sticky", 16'(bus.lock_lost_sticky), 16'd1);
      checkOutput("runloss_count", 16'(bus.lock_loss_count), 16'd1);
      checkOutput("runloss_state", 16'(bus.seq_state), 16'd0);
      stepCycles(1);
      checkOutput("runloss_count2", 16'(bus.lock_loss_count), 16'd1);
      runUp("relock");

      // Lock loss mid-RELEASE
      doReset();
      applyStimulus(1'b1, 1'b0);
      stepCycles(13);
      checkOutput("midrel_e12_stages", 16'(bus.rst_stage_out), 16'b100);
      applyStimulus(1'b0, 1'b0);
      stepCycles(1);
      checkOutput("midrel_stages", 16'(bus.rst_stage_out), 16'b111);
      checkOutput("midrel_count", 16'(bus.lock_loss_count), 16'd1);
      checkOutput("midrel_state", 16'(bus.seq_state), 16'd0);

      // Software reset in RUN; diagnostics stay sticky=1, count=1
      runUp("swup");
      applyStimulus(1'b1, 1'b1);
      stepCycles(1);
      checkOutput("sw_stages", 16'(bus.rst_stage_out), 16'b111);
      checkOutput("sw_ready", 16'(bus.sys_ready), 16'd0);
      checkOutput("sw_state", 16'(bus.seq_state), 16'd4);
      applyStimulus(1'b1, 1'b0);
      stepCycles(3);
      checkOutput("sw_state_x3", 16'(bus.seq_state), 16'd4);
      stepCycles(1);
      checkOutput("sw_state_x4", 16'(bus.seq_state), 16'd0);
      stepCycles(1);
      checkOutput("sw_restable", 16'(bus.seq_state), 16'd1);
      stepCycles(2);
      applyStimulus(1'b1, 1'b1);
      stepCycles(1);
      checkOutput("sw_ignored_stable", 16'(bus.seq_state), 16'd1);
      applyStimulus(1'b1, 1'b0);
      stepCycles(4);
      checkOutput("sw_e7_stages", 16'(bus.rst_stage_out), 16'b111);
      stepCycles(1);
      checkOutput("sw_e8_stages", 16'(bus.rst_stage_out), 16'b110);
      checkOutput("sw_diag_count", 16'(bus.lock_loss_count), 16'd1);
      checkOutput("sw_diag_sticky", 16'(bus.lock_lost_sticky), 16'd1);

      // Saturation of the loss counter
      doReset();
      for (int i = 0; i < 300; i++) begin
         runUp("sat");
         applyStimulus(1'b0, 1'b0);
         stepCycles(1);
         if (i == 254) begin
            checkOutput("sat_255th", 16'(bus.lock_loss_count), 16'd255);
         end
      end
      checkOutput("sat_final", 16'(bus.lock_loss_count), 16'd255);

      // Lock loss wins over a simultaneous software reset
      doReset();
      runUp("prio");
      applyStimulus(1'b0, 1'b1);
      stepCycles(1);
      checkOutput("prio_state", 16'(bus.seq_state), 16'd0);
      checkOutput("prio_count", 16'(bus.lock_loss_count), 16'd1);
      checkOutput("prio_stages", 16'(bus.rst_stage_out), 16'b111);
      applyStimulus(1'b0, 1'b0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
